// File: rtl/pkt_attr_priority_merge_if.sv
// rtl/pkt_attr_priority_merge_if.sv - parser-result inputs, winner output stream and statistics
// The master drives parser results and out_ready; the slave is the merge block.
interface pkt_attr_priority_merge_if #(
  parameter int NUM_PARSERS          = 4,
  parameter int ATTRIBUTE_DATA_WIDTH = 135,
  parameter int CNT_WIDTH            = 32
);
  logic                                        in_valid;
  logic                                        in_tlast;
  logic [NUM_PARSERS-1:0]                      in_pkt_valid;
  logic [NUM_PARSERS*ATTRIBUTE_DATA_WIDTH-1:0] in_pkt_attributes;
  logic                                        out_valid;
  logic [ATTRIBUTE_DATA_WIDTH-1:0]             out_attributes;
  logic                                        out_ready;
  logic [CNT_WIDTH-1:0]                        no_result_cnt;
  logic [CNT_WIDTH-1:0]                        drop_cnt;

  modport master (
    output in_valid, in_tlast, in_pkt_valid, in_pkt_attributes, out_ready,
    input  out_valid, out_attributes, no_result_cnt, drop_cnt
  );

  modport slave (
    input  in_valid, in_tlast, in_pkt_valid, in_pkt_attributes, out_ready,
    output out_valid, out_attributes, no_result_cnt, drop_cnt
  );
endinterface

// File: rtl/pkt_attr_priority_merge.sv
// rtl/pkt_attr_priority_merge.sv - per-packet priority merge of parser results into an output FIFO
// A delayed tlast closes each packet's result window; the highest PRTCL_ID seen in it is queued.
module pkt_attr_priority_merge #(
  parameter int NUM_PARSERS          = 4,
  parameter int ATTRIBUTE_DATA_WIDTH = 135,
  parameter int PRTCL_ID_OFFSET      = 125,
  parameter int PRTCL_ID_WIDTH       = 2,
  parameter int RESULT_LATENCY       = 2,
  parameter int FIFO_DEPTH           = 4,
  parameter int CNT_WIDTH            = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  pkt_attr_priority_merge_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef logic [ATTRIBUTE_DATA_WIDTH-1:0] attr_t;
  typedef logic [PRTCL_ID_WIDTH-1:0]       id_t;

  logic [RESULT_LATENCY-1:0] close_pipe_q, close_pipe_d;
  logic                      close;

  logic  cand_v_q, cand_v_d;
  attr_t cand_attr_q, cand_attr_d;
  id_t   cand_id_q, cand_id_d;

  logic  win_v;
  attr_t win_attr;
  id_t   win_id;
  attr_t slot;

  attr_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  attr_t          head_q, head_d;

  logic push_req, push_ok, pop, full, no_res, drop;
  logic [CNT_WIDTH-1:0] no_result_cnt_q, no_result_cnt_d, drop_cnt_q, drop_cnt_d;

  always_comb begin
    close_pipe_d    = '0;
    close_pipe_d[0] = bus.in_valid & bus.in_tlast;
    for (int i = 1; i < RESULT_LATENCY; i++) begin
      close_pipe_d[i] = close_pipe_q[i-1];
    end
  end

  assign close = close_pipe_q[RESULT_LATENCY-1];

  // Strict '>' gives ties to whoever is already held: candidate first, then lower parser index.
  always_comb begin
    win_v    = cand_v_q;
    win_attr = cand_attr_q;
    win_id   = cand_id_q;
    slot     = '0;
    for (int i = 0; i < NUM_PARSERS; i++) begin
      slot = bus.in_pkt_attributes[i*ATTRIBUTE_DATA_WIDTH +: ATTRIBUTE_DATA_WIDTH];
      if (bus.in_pkt_valid[i] && (!win_v || (slot[PRTCL_ID_OFFSET +: PRTCL_ID_WIDTH] > win_id))) begin
        win_v    = 1'b1;
        win_attr = slot;
        win_id   = slot[PRTCL_ID_OFFSET +: PRTCL_ID_WIDTH];
      end
    end
  end

  always_comb begin
    cand_v_d    = win_v & ~close;
    cand_attr_d = win_attr;
    cand_id_d   = win_id;
  end

  assign pop      = (count_q != '0) & bus.out_ready;
  assign full     = (count_q == FULL_CNT);
  assign push_req = close & win_v;
  assign push_ok  = push_req & (~full | pop);
  assign drop     = push_req & ~push_ok;
  assign no_res   = close & ~win_v;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - CW'(1);
    end
    // The head register is refreshed from memory, or bypassed when the new head is being written now.
    head_d = head_q;
    if (count_d != '0) begin
      if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
        head_d = win_attr;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_comb begin
    no_result_cnt_d = no_result_cnt_q;
    if (no_res && (no_result_cnt_q != '1)) begin
      no_result_cnt_d = no_result_cnt_q + CNT_WIDTH'(1);
    end
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      close_pipe_q    <= '0;
      cand_v_q        <= 1'b0;
      cand_attr_q     <= '0;
      cand_id_q       <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      head_q          <= '0;
      no_result_cnt_q <= '0;
      drop_cnt_q      <= '0;
    end else begin
      close_pipe_q    <= close_pipe_d;
      cand_v_q        <= cand_v_d;
      cand_attr_q     <= cand_attr_d;
      cand_id_q       <= cand_id_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      head_q          <= head_d;
      no_result_cnt_q <= no_result_cnt_d;
      drop_cnt_q      <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= win_attr;
    end
  end

  assign bus.out_valid      = (count_q != '0);
  assign bus.out_attributes = head_q;
  assign bus.no_result_cnt  = no_result_cnt_q;
  assign bus.drop_cnt       = drop_cnt_q;
endmodule

// File: tb/tb_pkt_attr_priority_merge.sv
// tb/tb_pkt_attr_priority_merge.sv - directed self-checking bench for pkt_attr_priority_merge
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
module tb_pkt_attr_priority_merge;
  localparam int NP = 4;
  localparam int W  = 135;
  localparam int CN = 32;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  pkt_attr_priority_merge_if #(.NUM_PARSERS(NP), .ATTRIBUTE_DATA_WIDTH(W), .CNT_WIDTH(CN)) bus ();

  pkt_attr_priority_merge #(
    .NUM_PARSERS(NP), .ATTRIBUTE_DATA_WIDTH(W), .PRTCL_ID_OFFSET(125), .PRTCL_ID_WIDTH(2),
    .RESULT_LATENCY(2), .FIFO_DEPTH(4), .CNT_WIDTH(CN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] word(input logic [1:0] id, input logic [31:0] tag);
    logic [W-1:0] r;
    r          = '0;
    r[126:125] = id;
    r[31:0]    = tag;
    return r;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic t, input logic [3:0] pv,
                     input logic [W-1:0] a0, input logic [W-1:0] a1,
                     input logic [W-1:0] a2, input logic [W-1:0] a3);
    bus.in_valid          = v;
    bus.in_tlast          = t;
    bus.in_pkt_valid      = pv;
    bus.in_pkt_attributes = {a3, a2, a1, a0};
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 4'b0000, '0, '0, '0, '0);
  endtask

  logic [W-1:0] exp_q [4];

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_tlast = 1'b0;
    bus.in_pkt_valid = '0;
    bus.in_pkt_attributes = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst_out_valid", W'(bus.out_valid), '0);
    check("rst_out_attr", bus.out_attributes, '0);
    check("rst_no_result", W'(bus.no_result_cnt), '0);
    check("rst_drop", W'(bus.drop_cnt), '0);

    // Highest PRTCL_ID across the window wins; lands the cycle after close.
    cyc(1, 0, 4'b0000, '0, '0, '0, '0);
    cyc(1, 0, 4'b0000, '0, '0, '0, '0);
    cyc(1, 1, 4'b0000, '0, '0, '0, '0);
    cyc(0, 0, 4'b0001, word(2'd0, 32'hA), '0, '0, '0);
    check("t1_not_yet", W'(bus.out_valid), '0);
    cyc(0, 0, 4'b0100, '0, '0, word(2'd3, 32'hB), '0);
    check("t1_valid", W'(bus.out_valid), W'(1));
    check("t1_word", bus.out_attributes, word(2'd3, 32'hB));
    check("t1_no_result", W'(bus.no_result_cnt), '0);
    idle();
    check("t1_stable", bus.out_attributes, word(2'd3, 32'hB));
    bus.out_ready = 1'b1;
    idle();
    bus.out_ready = 1'b0;
    check("t1_empty", W'(bus.out_valid), '0);
    check("t1_hold_last", bus.out_attributes, word(2'd3, 32'hB));

    // Same-cycle tie goes to the lower parser index.
    cyc(1, 1, 4'b0000, '0, '0, '0, '0);
    idle();
    cyc(0, 0, 4'b1010, '0, word(2'd2, 32'h11), '0, word(2'd2, 32'h33));
    check("t2_tie_low_idx", bus.out_attributes, word(2'd2, 32'h11));
    bus.out_ready = 1'b1;
    idle();
    bus.out_ready = 1'b0;

    // Tie between held candidate and a later pulse goes to the held candidate.
    cyc(1, 1, 4'b0000, '0, '0, '0, '0);
    cyc(0, 0, 4'b1000, '0, '0, '0, word(2'd1, 32'h44));
    cyc(0, 0, 4'b0001, word(2'd1, 32'h55), '0, '0, '0);
    check("t2_tie_held", bus.out_attributes, word(2'd1, 32'h44));
    bus.out_ready = 1'b1;
    idle();
    bus.out_ready = 1'b0;

    // No result at all.
    cyc(1, 1, 4'b0000, '0, '0, '0, '0);
    idle();
    idle();
    check("t3_no_result", W'(bus.no_result_cnt), W'(1));
    check("t3_no_push", W'(bus.out_valid), '0);

    // Six back-to-back packets into a 4-deep FIFO with no drain.
    for (int c = 0; c < 8; c++) begin
      cyc((c < 6), (c < 6), (c >= 2) ? 4'b0001 : 4'b0000,
          word(2'd1, 32'h100 + 32'(c) - 32'd2), '0, '0, '0);
    end
    check("t4_drop", W'(bus.drop_cnt), W'(2));
    check("t4_head", bus.out_attributes, word(2'd1, 32'h100));
    check("t4_no_result", W'(bus.no_result_cnt), W'(1));

    // Full FIFO with a pop in the close cycle still accepts the push.
    cyc(1, 1, 4'b0000, '0, '0, '0, '0);
    idle();
    bus.out_ready = 1'b1;
    cyc(0, 0, 4'b0001, word(2'd1, 32'h200), '0, '0, '0);
    check("t5_drop_same", W'(bus.drop_cnt), W'(2));
    exp_q[0] = word(2'd1, 32'h101);
    exp_q[1] = word(2'd1, 32'h102);
    exp_q[2] = word(2'd1, 32'h103);
    exp_q[3] = word(2'd1, 32'h200);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t5_valid%0d", k), W'(bus.out_valid), W'(1));
      check($sformatf("t5_word%0d", k), bus.out_attributes, exp_q[k]);
      idle();
    end
    check("t5_drained", W'(bus.out_valid), '0);
    bus.out_ready = 1'b0;

    // Reset with a close pending and a candidate held.
    cyc(1, 1, 4'b0000, '0, '0, '0, '0);
    cyc(0, 0, 4'b0001, word(2'd3, 32'h77), '0, '0, '0);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    check("t6_valid", W'(bus.out_valid), '0);
    check("t6_no_result", W'(bus.no_result_cnt), '0);
    check("t6_drop", W'(bus.drop_cnt), '0);
    for (int k = 0; k < 5; k++) begin
      idle();
      check($sformatf("t6_stale%0d", k), W'(bus.out_valid), '0);
    end
    check("t6_no_result_after", W'(bus.no_result_cnt), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pkt_attr_priority_merge.md
Name: pkt_attr_priority_merge

Overview:
- Sits directly downstream of the protocol-combination parsers (WHEN_NO_HIT and its sibling combination parsers) in the packet analyzer.
- Collects the one-cycle pkt_valid/pkt_attributes results that all parsers produce for the same packet.
- Selects a single winning attribute word per packet by PRTCL_ID priority and queues it in a small FIFO.
- The rule/statistics lookup stage drains the FIFO over a valid/ready handshake.

Parameters:
- NUM_PARSERS, 4, number of parser result inputs; index 0 = lowest index.
- ATTRIBUTE_DATA_WIDTH, 135, width of one attribute word.
- PRTCL_ID_OFFSET, 125, bit position of the PRTCL_ID field inside an attribute word.
- PRTCL_ID_WIDTH, 2, width of the PRTCL_ID field.
- RESULT_LATENCY, 2, maximum cycles from a stream tlast beat to the last parser result for that packet.
- FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2.
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  stream beat valid, same stream the parsers see.
- in_tlast  in  1  last beat of the packet; qualified by in_valid.
- in_pkt_valid  in  NUM_PARSERS  per-parser result pulse.
- in_pkt_attributes  in  NUM_PARSERS*ATTRIBUTE_DATA_WIDTH  per-parser attributes; parser i occupies slice i.
- out_valid  out  1  FIFO head valid.
- out_attributes  out  ATTRIBUTE_DATA_WIDTH  FIFO head data.
- out_ready  in  1  downstream accept.
- no_result_cnt  out  CNT_WIDTH  packets closed with no parser result.
- drop_cnt  out  CNT_WIDTH  winners discarded because the FIFO was full.

Behaviour:
- Reset (async, active-high):
  - out_valid=0, out_attributes=0, counters=0.
  - FIFO empty; candidate cleared; close pipeline cleared.
- Packet close:
  - A shift register delays (in_valid & in_tlast) by RESULT_LATENCY cycles.
  - Its output "close" marks the cycle in which the current packet's result window ends, inclusive.
- Candidate register (valid bit + attribute word + PRTCL_ID):
  - Each cycle, take the in_pkt_valid inputs plus the held candidate.
  - Highest PRTCL_ID wins.
  - Ties between inputs go to the lowest parser index.
  - A tie between the held candidate and a new input goes to the held candidate (first arrival).
- Close cycle:
  - Winner = candidate merged with same-cycle pulses, using the rules above.
  - If the winner is valid, push it to the FIFO; otherwise no_result_cnt++.
  - Candidate is cleared at the same edge.
  - Pulses arriving in the close cycle belong to the closing packet.
- FIFO:
  - Circular pointers with wrap-around.
  - Occupancy counter, width log2(FIFO_DEPTH)+1.
  - Push-latency: winner appears on out_valid the cycle after the close cycle when the FIFO was empty.
  - Pop when out_valid & out_ready; out_attributes is stable while out_valid=1 and out_ready=0.
  - Full and push without a same-cycle pop: winner discarded, drop_cnt++.
  - Full with a same-cycle pop: the push succeeds; no drop.
  - Empty: out_valid=0; out_attributes holds its last value.
- Counters: saturate at all-ones and never wrap.
- Overlap: the next packet's beats may arrive during the close window; new beats do not affect the closing packet. A parser guarantees its next-packet results come more than RESULT_LATENCY cycles after the prior tlast.
- Reset mid-packet: all state is discarded; no partial push after reset release.
- Results while no packet is open (no beats since the last close) are still captured; they close at the next delayed tlast.

Test Plan:
- Single packet, 3 beats, tlast at cycle 10; parser 0 pulses PRTCL_ID=0 at cycle 11 and parser 2 pulses PRTCL_ID=3 at cycle 12 -> out_valid=1 at cycle 13 with parser 2's word; no_result_cnt=0.
- Two parsers pulse PRTCL_ID=2 in the same cycle (parsers 1 and 3) -> parser 1's word is output.
- Packet with no parser pulse -> nothing pushed; no_result_cnt increments 0->1; out_valid stays 0.
- out_ready=0, six back-to-back 1-beat packets each with one result -> FIFO holds the first 4; drop_cnt=2. Then out_ready=1 -> exactly 4 words popped in order, then out_valid=0.
- FIFO full, out_ready=1 in a close cycle -> push accepted; drop_cnt unchanged; occupancy stays 4.
- Reset asserted 1 cycle after a tlast with a pending candidate -> after release out_valid=0, counters 0, and no stale word is ever output.
